forward_unit: RTL and testbench
===============================

FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 CLOCK  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 RESET  in  1  asynchronous, active-low reset.
REQ-003 ID_RsAddr_IN, ID_RtAddr_IN  in  5 each  source registers of the instruction in ID.
REQ-004 ID_WriteReg_IN  in  5, ID_RegWrite_IN  in  1, ID_MemRead_IN  in  1  destination, write-enable and load flag of the ID instruction.
REQ-005 OperandA_IN, OperandB_IN  in  32 each  register-file operands already latched in ID/EXE.
REQ-006 MEM_ALUResult_IN  in  32  result of the instruction now in MEM; WB_Data_IN  in  32  write-back value of the instruction now in WB.
REQ-007 FOperandA_OUT, FOperandB_OUT  out  32 each  operands with the MEM-stage result substituted per operand; Alu_forward_OUT  out  1  select for them.
REQ-008 S_operandA_OUT, S_operandB_OUT  out  32 each  operands with the WB value substituted per operand; mem_forward_OUT  out  1  select for them.
REQ-009 Stall_OUT  out  1  freezes PC and IF/ID and inserts a bubble into ID/EXE.

Function
REQ-010 Keep a three-entry tag pipeline. EX_tag holds {RsAddr, RtAddr, WriteReg, RegWrite, MemRead} of the instruction in EXE. MEM_tag and WB_tag hold {WriteReg, RegWrite, MemRead}.
REQ-011 Each cycle: WB_tag <= MEM_tag, MEM_tag <= EX_tag, and EX_tag <= the ID fields. When Stall_OUT=1, EX_tag instead gets a bubble (RegWrite=0, MemRead=0).
REQ-012 A match exists when tag RegWrite=1, tag WriteReg != 0, and tag WriteReg equals the source address. Register 0 never forwards.
REQ-013 Alu_forward_OUT=1 when MEM_tag matches either EX_tag source. For each operand, FOperandX_OUT = MEM_ALUResult_IN if that operand matches, else OperandX_IN.
REQ-014 mem_forward_OUT=1 when WB_tag matches either source and Alu_forward_OUT=0. For each operand, S_operandX_OUT = WB_Data_IN if it matches WB_tag, else OperandX_IN.
REQ-015 Priority when both match the same operand: the MEM-stage (younger) value wins. When Alu_forward_OUT=1, an operand matching only WB_tag takes WB_Data_IN within FOperandX_OUT.
REQ-016 A MEM_tag with MemRead=1 never drives the MEM_ALUResult_IN substitution, because its value is an address, not data.
REQ-017 Load-use FSM, states RUN and HOLD:
- RUN -> HOLD when EX_tag has MemRead=1 and RegWrite=1 and its WriteReg matches ID_RsAddr_IN or ID_RtAddr_IN.
- HOLD -> RUN unconditionally after one cycle.
REQ-018 Stall_OUT is combinational (RUN and load-use condition true). HOLD does not restart a stall for the same instruction pair, so the maximum stall is 1 cycle per load.
REQ-019 Forward selects and operand outputs are combinational from registered tags and current data inputs. Latency is 0 cycles from the data inputs.
REQ-020 Back-to-back loads to the same destination stall only against the youngest in-flight load.

Reset
REQ-021 While RESET=0: all tags are bubbles and the FSM is in RUN. Alu_forward_OUT=0, mem_forward_OUT=0, Stall_OUT=0, and the operand outputs equal OperandX_IN.
REQ-022 Reset asserted mid-stall discards the stall. The first rising edge after release loads EX_tag from ID normally.

Configuration
REQ-023 Macro FWD_PERF_EN adds two outputs, StallCount_OUT and FwdCount_OUT, each 16 bits, saturating at 0xFFFF and cleared by reset.
- StallCount_OUT increments every cycle Stall_OUT=1.
- FwdCount_OUT increments every cycle either forward select is 1.
REQ-024 Without FWD_PERF_EN, neither the ports nor the counters exist. All other behaviour is identical.

Structure
REQ-025 Package fwd_pkg holds:
- the typedef for the tag record;
- the bubble constant;
- the constant REG_ZERO=5'd0;
- the FSM state enum.
REQ-026 One sub-module, fwd_match, is the per-operand comparator and mux. It is instantiated once for operand A and once for operand B.

Verification
REQ-027 ADD $3 followed immediately by SUB using $3 as Rs, MEM_ALUResult_IN=0x00000005 -> Alu_forward_OUT=1, FOperandA_OUT=0x00000005, FOperandB_OUT=OperandB_IN.
REQ-028 Producer two instructions ahead writes $4, WB_Data_IN=0xDEADBEEF, consumer uses $4 as Rt -> mem_forward_OUT=1, S_operandB_OUT=0xDEADBEEF, Alu_forward_OUT=0.
REQ-029 LW $5 followed by ADD reading $5 -> Stall_OUT=1 for exactly 1 cycle, then a bubble is in EXE. The next cycle gives mem_forward_OUT=1 with the loaded WB_Data_IN.
REQ-030 Producer writes $0 with RegWrite=1, consumer reads $0 -> both selects 0, outputs equal OperandX_IN.
REQ-031 $6 is written in both MEM (0x11) and WB (0x22), consumer reads $6 -> Alu_forward_OUT=1, FOperandA_OUT=0x11.
REQ-032 RESET pulsed low during HOLD -> Stall_OUT=0 immediately and all selects are 0. With FWD_PERF_EN defined, the counters read 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types, constants and the tag-compare helper for the forwarding unit.
package fwd_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0] write_reg;
      logic             reg_write;
      logic             mem_read;
   } dst_tag_t;

   typedef struct packed {
      logic [REG_W-1:0] rs_addr;
      logic [REG_W-1:0] rt_addr;
      dst_tag_t         dst;
   } ex_tag_t;

   localparam ex_tag_t TAG_BUBBLE = '0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } fsm_state_e;

   // A producer hits a source only if it writes a real (non-zero) register.
   function automatic logic tag_match(input dst_tag_t tag, input logic [REG_W-1:0] src);
      return tag.reg_write && (tag.write_reg != REG_ZERO) && (tag.write_reg == src);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand comparator and substitution mux against the MEM and WB stage tags.
module fwd_match
   import fwd_pkg::*;
(
   input  dst_tag_t            mem_tag_i,
   input  dst_tag_t            wb_tag_i,
   input  logic [REG_W-1:0]    src_addr_i,
   input  logic [DATA_W-1:0]   operand_i,
   input  logic [DATA_W-1:0]   mem_data_i,
   input  logic [DATA_W-1:0]   wb_data_i,
   input  logic                alu_fwd_i,
   output logic                mem_hit_o,
   output logic                wb_hit_o,
   output logic [DATA_W-1:0]   f_operand_o,
   output logic [DATA_W-1:0]   s_operand_o
);

   // A load in MEM only carries its address, so it can never feed this operand.
   assign mem_hit_o = tag_match(mem_tag_i, src_addr_i) && !mem_tag_i.mem_read;
   assign wb_hit_o  = tag_match(wb_tag_i, src_addr_i);

   always_comb begin
      f_operand_o = operand_i;
      s_operand_o = operand_i;
      if (mem_hit_o) begin
         f_operand_o = mem_data_i;
      end else if (alu_fwd_i && wb_hit_o) begin
         f_operand_o = wb_data_i;
      end
      if (wb_hit_o) begin
         s_operand_o = wb_data_i;
      end
   end

endmodule

// File: rtl/forward_unit.sv
// Operand forwarding and load-use stall detection for a five-stage pipeline.
// Optional macro FWD_PERF_EN adds saturating stall / forward event counters.
module forward_unit
   import fwd_pkg::*;
(
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [REG_W-1:0]  ID_RsAddr_IN,
   input  logic [REG_W-1:0]  ID_RtAddr_IN,
   input  logic [REG_W-1:0]  ID_WriteReg_IN,
   input  logic              ID_RegWrite_IN,
   input  logic              ID_MemRead_IN,
   input  logic [DATA_W-1:0] OperandA_IN,
   input  logic [DATA_W-1:0] OperandB_IN,
   input  logic [DATA_W-1:0] MEM_ALUResult_IN,
   input  logic [DATA_W-1:0] WB_Data_IN,
   output logic [DATA_W-1:0] FOperandA_OUT,
   output logic [DATA_W-1:0] FOperandB_OUT,
   output logic              Alu_forward_OUT,
   output logic [DATA_W-1:0] S_operandA_OUT,
   output logic [DATA_W-1:0] S_operandB_OUT,
   output logic              mem_forward_OUT,
   output logic              Stall_OUT
`ifdef FWD_PERF_EN
   ,
   output logic [CNT_W-1:0]  StallCount_OUT,
   output logic [CNT_W-1:0]  FwdCount_OUT
`endif
);

   ex_tag_t    ex_tag_q;
   ex_tag_t    ex_tag_d;
   dst_tag_t   mem_tag_q;
   dst_tag_t   wb_tag_q;
   fsm_state_e state_q;

   logic load_use_c;
   logic stall_c;
   logic mem_hit_a_c, mem_hit_b_c;
   logic wb_hit_a_c, wb_hit_b_c;
   logic alu_fwd_c;
   logic mem_fwd_c;

   // Only the load currently in EXE can create a load-use hazard.
   assign load_use_c = ex_tag_q.dst.mem_read &&
                       (tag_match(ex_tag_q.dst, ID_RsAddr_IN) ||
                        tag_match(ex_tag_q.dst, ID_RtAddr_IN));
   assign stall_c    = (state_q == ST_RUN) && load_use_c;

   always_comb begin
      ex_tag_d = TAG_BUBBLE;
      if (!stall_c) begin
         ex_tag_d.rs_addr       = ID_RsAddr_IN;
         ex_tag_d.rt_addr       = ID_RtAddr_IN;
         ex_tag_d.dst.write_reg = ID_WriteReg_IN;
         ex_tag_d.dst.reg_write = ID_RegWrite_IN;
         ex_tag_d.dst.mem_read  = ID_MemRead_IN;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         ex_tag_q  <= TAG_BUBBLE;
         mem_tag_q <= TAG_BUBBLE.dst;
         wb_tag_q  <= TAG_BUBBLE.dst;
      end else begin
         ex_tag_q  <= ex_tag_d;
         mem_tag_q <= ex_tag_q.dst;
         wb_tag_q  <= mem_tag_q;
      end
   end

   // HOLD blocks a second stall for the same load/consumer pair.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:  if (load_use_c) state_q <= ST_HOLD;
            ST_HOLD: state_q <= ST_RUN;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   fwd_match u_match_a (
      .mem_tag_i   (mem_tag_q),
      .wb_tag_i    (wb_tag_q),
      .src_addr_i  (ex_tag_q.rs_addr),
      .operand_i   (OperandA_IN),
      .mem_data_i  (MEM_ALUResult_IN),
      .wb_data_i   (WB_Data_IN),
      .alu_fwd_i   (alu_fwd_c),
      .mem_hit_o   (mem_hit_a_c),
      .wb_hit_o    (wb_hit_a_c),
      .f_operand_o (FOperandA_OUT),
      .s_operand_o (S_operandA_OUT)
   );

   fwd_match u_match_b (
      .mem_tag_i   (mem_tag_q),
      .wb_tag_i    (wb_tag_q),
      .src_addr_i  (ex_tag_q.rt_addr),
      .operand_i   (OperandB_IN),
      .mem_data_i  (MEM_ALUResult_IN),
      .wb_data_i   (WB_Data_IN),
      .alu_fwd_i   (alu_fwd_c),
      .mem_hit_o   (mem_hit_b_c),
      .wb_hit_o    (wb_hit_b_c),
      .f_operand_o (FOperandB_OUT),
      .s_operand_o (S_operandB_OUT)
   );

   assign alu_fwd_c = mem_hit_a_c || mem_hit_b_c;
   assign mem_fwd_c = (wb_hit_a_c || wb_hit_b_c) && !alu_fwd_c;

   assign Alu_forward_OUT = alu_fwd_c;
   assign mem_forward_OUT = mem_fwd_c;
   assign Stall_OUT       = stall_c;

`ifdef FWD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] fwd_cnt_q;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if ((alu_fwd_c || mem_fwd_c) && (fwd_cnt_q != {CNT_W{1'b1}})) begin
            fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
         end
      end
   end

   assign StallCount_OUT = stall_cnt_q;
   assign FwdCount_OUT   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forward_unit.sv
// Scoreboard bench for forward_unit: driver predicts from an instruction-level
// pipeline model and queues expectations; a negedge monitor pops and compares.
module tb_forward_unit;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wr;
      logic       rw;
      logic       mr;
   } instr_t;

   typedef struct packed {
      logic        alu;
      logic        memf;
      logic        stall;
      logic [31:0] fa;
      logic [31:0] fb;
      logic [31:0] sa;
      logic [31:0] sb;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b0;
   logic [4:0]  ID_RsAddr_IN = '0, ID_RtAddr_IN = '0, ID_WriteReg_IN = '0;
   logic        ID_RegWrite_IN = 1'b0, ID_MemRead_IN = 1'b0;
   logic [31:0] OperandA_IN = '0, OperandB_IN = '0, MEM_ALUResult_IN = '0, WB_Data_IN = '0;
   logic [31:0] FOperandA_OUT, FOperandB_OUT, S_operandA_OUT, S_operandB_OUT;
   logic        Alu_forward_OUT, mem_forward_OUT, Stall_OUT;
`ifdef FWD_PERF_EN
   logic [15:0] StallCount_OUT, FwdCount_OUT;
`endif

   forward_unit dut (
      .CLOCK            (CLOCK),
      .RESET            (RESET),
      .ID_RsAddr_IN     (ID_RsAddr_IN),
      .ID_RtAddr_IN     (ID_RtAddr_IN),
      .ID_WriteReg_IN   (ID_WriteReg_IN),
      .ID_RegWrite_IN   (ID_RegWrite_IN),
      .ID_MemRead_IN    (ID_MemRead_IN),
      .OperandA_IN      (OperandA_IN),
      .OperandB_IN      (OperandB_IN),
      .MEM_ALUResult_IN (MEM_ALUResult_IN),
      .WB_Data_IN       (WB_Data_IN),
      .FOperandA_OUT    (FOperandA_OUT),
      .FOperandB_OUT    (FOperandB_OUT),
      .Alu_forward_OUT  (Alu_forward_OUT),
      .S_operandA_OUT   (S_operandA_OUT),
      .S_operandB_OUT   (S_operandB_OUT),
      .mem_forward_OUT  (mem_forward_OUT),
      .Stall_OUT        (Stall_OUT)
`ifdef FWD_PERF_EN
      ,
      .StallCount_OUT   (StallCount_OUT),
      .FwdCount_OUT     (FwdCount_OUT)
`endif
   );

   always #5 CLOCK = ~CLOCK;

   int     checks   = 0;
   int     failures = 0;
   exp_t   exp_q[$];

   // Reference model: the instructions occupying EXE, MEM and WB.
   instr_t pipe [3];
   bit     held;
   int     m_stall_cnt;
   int     m_fwd_cnt;

   localparam instr_t NOP = '0;

   function automatic instr_t mk(input int rs, input int rt, input int wr,
                                 input bit rw, input bit mr);
      instr_t i;
      i.rs = 5'(rs); i.rt = 5'(rt); i.wr = 5'(wr); i.rw = rw; i.mr = mr;
      return i;
   endfunction

   function automatic bit writes(input instr_t p, input logic [4:0] r);
      return p.rw && (p.wr != 5'd0) && (p.wr == r);
   endfunction

   function automatic exp_t predict(input instr_t id, input logic [31:0] opa, input logic [31:0] opb,
                                    input logic [31:0] memres, input logic [31:0] wbd);
      exp_t e;
      instr_t c;
      bit a_mem, b_mem, a_wb, b_wb;
      c     = pipe[0];
      a_mem = writes(pipe[1], c.rs) && !pipe[1].mr;
      b_mem = writes(pipe[1], c.rt) && !pipe[1].mr;
      a_wb  = writes(pipe[2], c.rs);
      b_wb  = writes(pipe[2], c.rt);
      e.alu   = a_mem || b_mem;
      e.memf  = (a_wb || b_wb) && !e.alu;
      e.fa    = a_mem ? memres : ((e.alu && a_wb) ? wbd : opa);
      e.fb    = b_mem ? memres : ((e.alu && b_wb) ? wbd : opb);
      e.sa    = a_wb ? wbd : opa;
      e.sb    = b_wb ? wbd : opb;
      e.stall = !held && pipe[0].mr && (writes(pipe[0], id.rs) || writes(pipe[0], id.rt));
      e.sc    = 16'(m_stall_cnt);
      e.fc    = 16'(m_fwd_cnt);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents one result.
   always @(negedge CLOCK) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("alu_forward", 32'(Alu_forward_OUT), 32'(e.alu));
         chk("mem_forward", 32'(mem_forward_OUT), 32'(e.memf));
         chk("stall",       32'(Stall_OUT),       32'(e.stall));
         chk("f_operand_a", FOperandA_OUT,  e.fa);
         chk("f_operand_b", FOperandB_OUT,  e.fb);
         chk("s_operand_a", S_operandA_OUT, e.sa);
         chk("s_operand_b", S_operandB_OUT, e.sb);
`ifdef FWD_PERF_EN
         chk("stall_count", 32'(StallCount_OUT), 32'(e.sc));
         chk("fwd_count",   32'(FwdCount_OUT),   32'(e.fc));
`endif
      end
   end

   // One cycle: drive ID/data at posedge+1, queue the prediction, advance the model.
   task automatic step(input instr_t id, input logic rst, input logic [31:0] memres,
                       input logic [31:0] wbd, output bit stalled);
      exp_t e;
      logic [31:0] opa, opb;
      opa = $urandom;
      opb = $urandom;
      RESET            = rst;
      ID_RsAddr_IN     = id.rs;
      ID_RtAddr_IN     = id.rt;
      ID_WriteReg_IN   = id.wr;
      ID_RegWrite_IN   = id.rw;
      ID_MemRead_IN    = id.mr;
      OperandA_IN      = opa;
      OperandB_IN      = opb;
      MEM_ALUResult_IN = memres;
      WB_Data_IN       = wbd;
      if (!rst) begin
         pipe[0] = NOP; pipe[1] = NOP; pipe[2] = NOP;
         held = 1'b0;
         m_stall_cnt = 0;
         m_fwd_cnt   = 0;
      end
      e = predict(id, opa, opb, memres, wbd);
      exp_q.push_back(e);
      stalled = e.stall;
      @(posedge CLOCK);
      #1;
      if (rst) begin
         if (e.stall && m_stall_cnt < 65535) m_stall_cnt++;
         if ((e.alu || e.memf) && m_fwd_cnt < 65535) m_fwd_cnt++;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = e.stall ? NOP : id;
         held    = e.stall;
      end
   endtask

   // Issue one instruction, repeating it while IF/ID is frozen by a stall.
   task automatic issue(input instr_t id, input logic [31:0] memres, input logic [31:0] wbd);
      bit st;
      int guard;
      guard = 0;
      step(id, 1'b1, memres, wbd, st);
      while (st && guard < 4) begin
         step(id, 1'b1, $urandom, $urandom, st);
         guard++;
      end
   endtask

   function automatic instr_t rand_instr();
      instr_t i;
      i.rs = 5'($urandom_range(0, 7));
      i.rt = 5'($urandom_range(0, 7));
      i.wr = 5'($urandom_range(0, 7));
      i.rw = ($urandom_range(0, 3) != 0);
      i.mr = i.rw && ($urandom_range(0, 2) == 0);
      return i;
   endfunction

   initial begin
      bit st;
      pipe[0] = NOP; pipe[1] = NOP; pipe[2] = NOP;
      held = 1'b0; m_stall_cnt = 0; m_fwd_cnt = 0;
      @(posedge CLOCK);
      #1;
      // Reset state with live data inputs.
      step(mk(3, 4, 5, 1, 1), 1'b0, $urandom, $urandom, st);
      step(mk(1, 2, 3, 1, 0), 1'b0, $urandom, $urandom, st);

      // ALU result forwarded from MEM to Rs.
      issue(mk(1, 2, 3, 1, 0), $urandom, $urandom);
      issue(mk(3, 7, 8, 1, 0), $urandom, $urandom);
      issue(NOP, 32'h0000_0005, $urandom);

      // WB value forwarded to Rt two instructions later.
      issue(mk(1, 2, 4, 1, 0), $urandom, $urandom);
      issue(mk(9, 10, 11, 1, 0), $urandom, $urandom);
      issue(mk(12, 4, 13, 1, 0), $urandom, $urandom);
      issue(NOP, $urandom, 32'hDEAD_BEEF);

      // Load-use: one stall, then the loaded value arrives from WB.
      issue(mk(1, 2, 5, 1, 1), $urandom, $urandom);
      issue(mk(5, 9, 10, 1, 0), $urandom, $urandom);
      issue(NOP, $urandom, 32'h1234_5678);

      // Writes to $0 never forward.
      issue(mk(1, 2, 0, 1, 0), $urandom, $urandom);
      issue(mk(0, 0, 7, 1, 0), $urandom, $urandom);
      issue(NOP, $urandom, $urandom);

      // $6 produced in both MEM and WB: the younger MEM value wins.
      issue(mk(1, 2, 6, 1, 0), $urandom, $urandom);
      issue(mk(1, 2, 6, 1, 0), $urandom, $urandom);
      issue(mk(6, 6, 9, 1, 0), $urandom, $urandom);
      issue(NOP, 32'h0000_0011, 32'h0000_0022);

      // Reset during the stall cycle and during HOLD.
      issue(mk(1, 2, 5, 1, 1), $urandom, $urandom);
      step(mk(5, 5, 9, 1, 0), 1'b0, $urandom, $urandom, st);
      step(mk(5, 5, 9, 1, 0), 1'b1, $urandom, $urandom, st);
      issue(mk(1, 2, 5, 1, 1), $urandom, $urandom);
      step(mk(5, 3, 9, 1, 0), 1'b1, $urandom, $urandom, st);
      step(mk(5, 3, 9, 1, 0), 1'b0, $urandom, $urandom, st);
      issue(mk(5, 3, 9, 1, 0), $urandom, $urandom);
      issue(NOP, $urandom, $urandom);

      // Back-to-back loads to the same register.
      issue(mk(1, 2, 5, 1, 1), $urandom, $urandom);
      issue(mk(1, 2, 5, 1, 1), $urandom, $urandom);
      issue(mk(5, 5, 6, 1, 0), $urandom, $urandom);

      for (int n = 0; n < 400; n++) begin
         issue(rand_instr(), $urandom, $urandom);
      end

      repeat (2) @(negedge CLOCK);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
